// File: rtl/fsk2_modulator.sv
// Binary FSK modulator: frames bytes as UART characters and drives a
// phase-continuous two-tone DDS whose signed 14-bit output feeds the DAC stage.
module fsk2_modulator #(
  parameter logic [31:0] FTW_MARK        = 32'h0666_6666,
  parameter logic [31:0] FTW_SPACE       = 32'h0CCC_CCCC,
  parameter logic [15:0] SAMPLES_PER_BIT = 16'd1000
) (
  input  logic        clk_sample,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [13:0] data_send,
  output logic        tx_bit,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] LAST_CYC = SAMPLES_PER_BIT - 16'd1;

  logic [1:0]  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] cyc_q, cyc_d;
  logic [2:0]  bit_q, bit_d;
  logic [31:0] acc_q, acc_d;
  logic [13:0] sample_q, sample_d;

  logic        bit_end;
  logic [7:0]  phase_idx;
  logic [6:0]  table_idx;
  logic [13:0] magnitude;

  // Quarter-wave table: round(8191 * sin(pi*k/128)), k = 0..64.
  function automatic logic [12:0] quarter_sine(input logic [6:0] k);
    case (k)
      7'd0:  return 13'd0;    7'd1:  return 13'd201;  7'd2:  return 13'd402;
      7'd3:  return 13'd603;  7'd4:  return 13'd803;  7'd5:  return 13'd1003;
      7'd6:  return 13'd1202; 7'd7:  return 13'd1400; 7'd8:  return 13'd1598;
      7'd9:  return 13'd1795; 7'd10: return 13'd1990; 7'd11: return 13'd2185;
      7'd12: return 13'd2378; 7'd13: return 13'd2569; 7'd14: return 13'd2759;
      7'd15: return 13'd2948; 7'd16: return 13'd3135; 7'd17: return 13'd3319;
      7'd18: return 13'd3502; 7'd19: return 13'd3683; 7'd20: return 13'd3861;
      7'd21: return 13'd4037; 7'd22: return 13'd4211; 7'd23: return 13'd4382;
      7'd24: return 13'd4551; 7'd25: return 13'd4716; 7'd26: return 13'd4879;
      7'd27: return 13'd5039; 7'd28: return 13'd5196; 7'd29: return 13'd5350;
      7'd30: return 13'd5501; 7'd31: return 13'd5648; 7'd32: return 13'd5792;
      7'd33: return 13'd5932; 7'd34: return 13'd6069; 7'd35: return 13'd6202;
      7'd36: return 13'd6332; 7'd37: return 13'd6457; 7'd38: return 13'd6579;
      7'd39: return 13'd6697; 7'd40: return 13'd6811; 7'd41: return 13'd6920;
      7'd42: return 13'd7026; 7'd43: return 13'd7127; 7'd44: return 13'd7224;
      7'd45: return 13'd7316; 7'd46: return 13'd7405; 7'd47: return 13'd7488;
      7'd48: return 13'd7567; 7'd49: return 13'd7642; 7'd50: return 13'd7712;
      7'd51: return 13'd7778; 7'd52: return 13'd7838; 7'd53: return 13'd7894;
      7'd54: return 13'd7946; 7'd55: return 13'd7992; 7'd56: return 13'd8034;
      7'd57: return 13'd8070; 7'd58: return 13'd8102; 7'd59: return 13'd8129;
      7'd60: return 13'd8152; 7'd61: return 13'd8169; 7'd62: return 13'd8181;
      7'd63: return 13'd8189;
      default: return 13'd8191;
    endcase
  endfunction

  assign bit_end    = (cyc_q == LAST_CYC);
  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_STOP) && bit_end;
  assign data_send  = sample_q;

  always_comb begin
    case (state_q)
      S_START: tx_bit = 1'b0;
      S_DATA:  tx_bit = shift_q[0];
      default: tx_bit = 1'b1;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    cyc_d   = bit_end ? 16'd0 : cyc_q + 16'd1;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        cyc_d = 16'd0;
        bit_d = 3'd0;
        if (in_valid) begin
          shift_d = in_data;
          state_d = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      default: if (bit_end) state_d = S_IDLE;
    endcase
  end

  // Folding the 8-bit phase onto the quarter table; negation is exact since
  // the table tops out at 8191, well inside the 14-bit signed range.
  always_comb begin
    phase_idx = acc_q[31:24];
    table_idx = phase_idx[6] ? (7'd64 - {1'b0, phase_idx[5:0]})
                             : {1'b0, phase_idx[5:0]};
    magnitude = {1'b0, quarter_sine(table_idx)};
    sample_d  = phase_idx[7] ? (~magnitude + 14'd1) : magnitude;
    acc_d     = acc_q + (tx_bit ? FTW_MARK : FTW_SPACE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= 8'd0;
      cyc_q    <= 16'd0;
      bit_q    <= 3'd0;
      acc_q    <= 32'd0;
      sample_q <= 14'd0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
    end
  end

endmodule

// File: tb/tb_fsk2_modulator.sv
// Scoreboard bench for fsk2_modulator: accepted bytes expand into expected
// per-cycle tx_bit streams; a monitor pops them and tracks an ideal sine DDS.
module tb_fsk2_modulator;

  localparam int          SPB   = 4;
  localparam logic [31:0] MARK  = 32'h4000_0000;
  localparam logic [31:0] SPACE = 32'h2000_0000;

  logic        clk_sample = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] data_send;
  logic        tx_bit;
  logic        busy;
  logic        frame_done;

  fsk2_modulator #(
    .FTW_MARK(MARK),
    .FTW_SPACE(SPACE),
    .SAMPLES_PER_BIT(16'(SPB))
  ) dut (
    .clk_sample(clk_sample),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_send(data_send),
    .tx_bit(tx_bit),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk_sample = ~clk_sample;

  int          checks = 0;
  int          errors = 0;
  bit          exp_q[$];
  logic [31:0] m_acc = 32'd0;
  int          m_ds = 0;
  bit          exp_ready = 1'b0;
  int          frames = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Ideal sine of the top 8 phase bits, rounded half away from zero.
  function automatic int sine_ref(input logic [31:0] acc);
    real v;
    v = 8191.0 * $sin(2.0 * 3.14159265358979323846 * real'(acc[31:24]) / 256.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic push_frame(input logic [7:0] d);
    bit b;
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
      for (int j = 0; j < SPB; j++) exp_q.push_back(b);
    end
    frames++;
  endtask

  // Drive one cycle's inputs mid-cycle; the model accepts when it is idle.
  task automatic step(input bit v, input logic [7:0] d, output bit accepted);
    @(negedge clk_sample);
    #1;
    in_valid = v;
    in_data  = d;
    accepted = v && exp_ready;
    if (accepted) push_frame(d);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), a);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc = 32'd0;
    m_ds  = 0;
  endtask

  initial begin : monitor
    bit was_idle;
    bit e_bit;
    bit e_done;
    forever begin
      @(negedge clk_sample);
      if (!rst_n) begin
        exp_ready = 1'b0;
      end else begin
        was_idle = (exp_q.size() == 0);
        if (was_idle) begin
          e_bit  = 1'b1;
          e_done = 1'b0;
        end else begin
          e_bit  = exp_q.pop_front();
          e_done = (exp_q.size() == 0);
        end
        check("tx_bit", int'(tx_bit), int'(e_bit));
        check("busy", int'(busy), int'(!was_idle));
        check("in_ready", int'(in_ready), int'(was_idle));
        check("frame_done", int'(frame_done), int'(e_done));
        check("data_send", int'($signed(data_send)), m_ds);
        m_ds      = sine_ref(m_acc);
        m_acc     = m_acc + (e_bit ? MARK : SPACE);
        exp_ready = was_idle;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit a;
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    model_reset();
    #2;
    check("rst_data_send", int'($signed(data_send)), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_bit", int'(tx_bit), 1);
    check("rst_frame_done", int'(frame_done), 0);
    repeat (3) @(posedge clk_sample);
    #1 rst_n = 1'b1;

    // Idle mark tone: 0, 0, 8191, 0, -8191, ...
    idle(10);

    // Single framed byte.
    step(1'b1, 8'hA5, a);
    check("accept_A5", int'(a), 1);
    idle(45);

    // Back-to-back with in_valid held high.
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      step(1'b1, (n == 0) ? 8'h00 : 8'hFF, a);
      if (a) n++;
    end
    check("b2b_accepts", n, 2);
    idle(45);

    // Random traffic, including junk on in_valid/in_data while busy.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom), a);
    idle(45);

    // Reset in the middle of a frame.
    step(1'b1, 8'h3C, a);
    for (int i = 0; i < 13; i++) step(1'($urandom), 8'($urandom), a);
    @(negedge clk_sample);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_data_send", int'($signed(data_send)), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_tx_bit", int'(tx_bit), 1);
    check("midrst_frame_done", int'(frame_done), 0);
    model_reset();
    repeat (2) @(posedge clk_sample);
    #1 rst_n = 1'b1;
    idle(10);

    step(1'b1, 8'h96, a);
    check("accept_after_reset", int'(a), 1);
    idle(45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk2_modulator.md
# fsk2_modulator

Binary FSK modulator that takes bytes from the UART receive path, frames them as UART characters (start bit, 8 data bits LSB first, stop bit) and synthesises a phase-continuous two-tone signal with a direct digital synthesiser. Its signed 14-bit sample output drives `data_send` of the AD9767 output stage, which converts it to offset binary for the DAC. The block runs entirely in the DAC sampling clock domain.

## Interface

Parameters:

- `FTW_MARK`, default 32'h0666_6666: tuning word for bit 1 (mark), approximately clk/40.
- `FTW_SPACE`, default 32'h0CCC_CCCC: tuning word for bit 0 (space), approximately clk/20.
- `SAMPLES_PER_BIT`, default 16'd1000: clock cycles per transmitted bit; legal range 2..65535.

Ports:

- `clk_sample` input 1: sampling clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous reset, active low.
- `in_data` input 8: byte to transmit.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block accepts a byte this cycle.
- `data_send` output 14: signed two's-complement sine sample, range ±8191.
- `tx_bit` output 1: bit currently being modulated (1 = mark).
- `busy` output 1: a frame is in progress.
- `frame_done` output 1: one-cycle pulse on the last cycle of the stop bit.

## Operation

**State machine.** States are IDLE, START, DATA and STOP.

- **IDLE**
  - `tx_bit`=1; the mark tone is transmitted continuously.
  - `in_ready`=1.
  - On `in_valid` && `in_ready`: latch `in_data` into the shift register and go to START.
- **START**
  - `tx_bit`=0 for `SAMPLES_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `tx_bit` = shift register bit 0 for `SAMPLES_PER_BIT` cycles per bit.
  - Shift right after each bit; after 8 bits go to STOP.
- **STOP**
  - `tx_bit`=1 for `SAMPLES_PER_BIT` cycles, then return to IDLE.
  - `frame_done` is high on the final cycle.

**Outputs and flags.**

- `in_ready` = (state==IDLE). It is combinational from the state register only, never from `in_valid`.
- `busy` = (state!=IDLE).
- `in_data` and `in_valid` are ignored while `busy`=1.
- Cycle counter: counts 0..`SAMPLES_PER_BIT`-1 and wraps to 0 on every bit boundary. Bit counter: 0..7, used in DATA.

**Synthesiser.**

- 32-bit phase accumulator: each cycle, acc <= acc + (`tx_bit` ? `FTW_MARK` : `FTW_SPACE`). Addition is modulo 2^32.
- The accumulator is never cleared except by reset, so phase stays continuous across bit and frame boundaries.
- Index p = acc[31:24], quadrant p[7:6], offset q = p[5:0].
- Quarter-wave table T[k] = round(8191·sin(πk/128)) for k=0..64, so T[0]=0 and T[64]=8191.
- Sample selection by quadrant:
  - quadrant 0: T[q]
  - quadrant 1: T[64−q]
  - quadrant 2: −T[q]
  - quadrant 3: −T[64−q]
- Negation is exact because the range is symmetric; no saturation is needed.
- `data_send` <= selected sample (registered).

## Timing

**Reset values (asynchronous).**

- State IDLE.
- acc=0; `data_send`=0.
- Shift register and counters 0.
- `tx_bit`=1, `in_ready`=1, `busy`=0, `frame_done`=0.

**Acceptance and frame length.**

- A handshake in cycle N makes `busy`=1 and `tx_bit`=0 from cycle N+1.
- A frame occupies exactly 10·`SAMPLES_PER_BIT` cycles, counted from cycle N+1.
- `in_ready` returns to 1 on the cycle after `frame_done`.
- Maximum throughput is one byte per 10·`SAMPLES_PER_BIT`+1 cycles.

**Synthesiser latency.**

- A `tx_bit` change affects the accumulator increment in the same cycle.
- `data_send` reflects the accumulator value of the previous cycle: 1 register of latency from acc to `data_send`.

**Boundary conditions.**

- `in_valid` held high continuously: a new byte is accepted on the first IDLE cycle after each frame.
- `in_valid` asserted in the same cycle as `frame_done`: not accepted, because `in_ready`=0.
- `SAMPLES_PER_BIT`=2: each bit lasts 2 cycles.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial frame is discarded.
- After reset deasserts, the first `data_send` update is T[0]=0, then the mark tone follows.

## Test plan

- **Reset.** Assert `rst_n`=0 mid-frame, then release. Required: `data_send`=0, `in_ready`=1, `busy`=0, `tx_bit`=1. No residual `frame_done`.
- **Tone synthesis.** Override `FTW_MARK`=32'h4000_0000 and idle. Required: `data_send` repeats 0, 8191, 0, −8191, starting the cycle after reset release.
- **Framing.** With `SAMPLES_PER_BIT`=4, send 8'hA5. Required `tx_bit` sequence, each bit held 4 cycles: 0, 1, 0, 1, 0, 0, 1, 0, 1, 1.
  - `busy` is high for exactly 40 cycles.
  - `frame_done` pulses on cycle 40.
- **Back-to-back.** Hold `in_valid`=1 with bytes 8'h00 then 8'hFF at `SAMPLES_PER_BIT`=4.
  - Required: the second acceptance happens exactly 41 cycles after the first.
  - 8'h00 gives 9 space bits then mark; 8'hFF gives 1 space bit then 9 mark bits.
- **Phase continuity.** Use `FTW_MARK`=32'h4000_0000, `FTW_SPACE`=32'h2000_0000 and `SAMPLES_PER_BIT`=3, then send one byte. Required:
  - acc advances by exactly the `tx_bit`-selected tuning word every cycle, with no phase jumps at bit boundaries.
  - `data_send` equals the table lookup of the previous acc in every cycle.
- **Ignored input.** Toggle `in_valid` and `in_data` randomly while `busy`=1. Required: the transmitted frame matches the originally latched byte, and no extra frame is started.
